// File: rtl/loop_recorder_if.sv
// Bus bundle between the loop recorder sequencer and its surroundings:
// sample source, buffer RAM port pair, DAC nibble and status.
interface loop_recorder_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 4
);
  logic              sample_stb;
  logic [DATA_W-1:0] sample_in;
  logic              rec_req;
  logic              play_req;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_waddr;
  logic [DATA_W-1:0] buf_wdata;
  logic [ADDR_W-1:0] buf_raddr;
  logic [DATA_W-1:0] buf_rdata;
  logic [DATA_W-1:0] audio_out;
  logic [ADDR_W:0]   rec_len;
  logic [1:0]        state;
  logic              full;

  // Environment side: sample source, request buttons, RAM read data.
  modport master (
    output sample_stb, sample_in, rec_req, play_req, buf_rdata,
    input  buf_we, buf_waddr, buf_wdata, buf_raddr, audio_out, rec_len, state, full
  );

  // Sequencer side.
  modport slave (
    input  sample_stb, sample_in, rec_req, play_req, buf_rdata,
    output buf_we, buf_waddr, buf_wdata, buf_raddr, audio_out, rec_len, state, full
  );
endinterface

// File: rtl/loop_recorder_ctrl.sv
// Record/playback sequencer for the audio sample buffer. Records strobed
// microphone samples into the buffer, then replays them as a seamless loop.
module loop_recorder_ctrl #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  loop_recorder_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRecord = 2'b01,
    StPlay   = 2'b10
  } state_e;

  localparam logic [ADDR_W-1:0] AddrOne = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LenOne  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CapM1   = {1'b0, {ADDR_W{1'b1}}};

  state_e              state_q, state_d;
  logic                rec_req_q, rec_req_d;
  logic                play_req_q, play_req_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic [DATA_W-1:0]   audio_q, audio_d;
  logic [ADDR_W:0]     rec_len_q, rec_len_d;
  logic                full_q, full_d;

  logic                rec_rise, play_rise, full_hit;
  logic [ADDR_W:0]     len_m1;

  assign rec_rise  = bus.rec_req & ~rec_req_q;
  assign play_rise = bus.play_req & ~play_req_q;
  // The write committing this cycle is the one that fills the buffer.
  assign full_hit  = (state_q == StRecord) && we_q && (count_q == CapM1);
  assign len_m1    = rec_len_q - LenOne;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rec_req_q  <= 1'b1;
      play_req_q <= 1'b1;
      waddr_q    <= '0;
      count_q    <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      raddr_q    <= '0;
      audio_q    <= '0;
      rec_len_q  <= '0;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rec_req_q  <= rec_req_d;
      play_req_q <= play_req_d;
      waddr_q    <= waddr_d;
      count_q    <= count_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      raddr_q    <= raddr_d;
      audio_q    <= audio_d;
      rec_len_q  <= rec_len_d;
      full_q     <= full_d;
    end
  end

  // Next-state decode; RECORD wins when both requests rise together.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (rec_rise) begin
          state_d = StRecord;
        end else if (play_rise && (rec_len_q != '0)) begin
          state_d = StPlay;
        end
      end
      StRecord: if (!bus.rec_req || full_hit) state_d = StIdle;
      StPlay:   if (!bus.play_req) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Pointer, write-strobe, length and audio updates driven by the FSM.
  always_comb begin
    rec_req_d  = bus.rec_req;
    play_req_d = bus.play_req;
    waddr_d    = waddr_q;
    count_d    = count_q;
    we_d       = 1'b0;
    wdata_d    = wdata_q;
    raddr_d    = raddr_q;
    audio_d    = audio_q;
    rec_len_d  = rec_len_q;
    full_d     = full_q;

    if (state_q == StIdle && state_d == StRecord) begin
      waddr_d = '0;
      count_d = '0;
      full_d  = 1'b0;
    end
    if (state_q == StIdle && state_d == StPlay) begin
      raddr_d = '0;
    end

    if (state_q == StRecord) begin
      if (we_q) begin
        waddr_d = waddr_q + AddrOne;
        count_d = count_q + LenOne;
      end
      // A strobe landing on the exit cycle is dropped so no write leaks into IDLE.
      if (bus.sample_stb && state_d == StRecord) begin
        we_d    = 1'b1;
        wdata_d = bus.sample_in;
      end
      if (state_d == StIdle) begin
        rec_len_d = count_q + {{ADDR_W{1'b0}}, we_q};
        full_d    = full_hit;
      end
    end

    if (bus.sample_stb) begin
      if (state_q == StPlay) begin
        audio_d = bus.buf_rdata;
        raddr_d = ({1'b0, raddr_q} == len_m1) ? '0 : raddr_q + AddrOne;
      end else begin
        audio_d = bus.sample_in;
      end
    end
  end

  assign bus.buf_we    = we_q;
  assign bus.buf_waddr = waddr_q;
  assign bus.buf_wdata = wdata_q;
  assign bus.buf_raddr = raddr_q;
  assign bus.audio_out = audio_q;
  assign bus.rec_len   = rec_len_q;
  assign bus.state     = state_q;
  assign bus.full      = full_q;

endmodule

// File: tb/tb_loop_recorder_ctrl.sv
// Directed bench: a full-size instance (ADDR_W=16) and a tiny one (ADDR_W=3)
// share the same stimulus; each has its own registered RAM model.
module tb_loop_recorder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stb = 1'b0;
  logic [3:0] smp = '0;
  logic       rec = 1'b0;
  logic       play = 1'b0;

  int total = 0;
  int bad = 0;
  int bad_we = 0;
  logic prev_we_a = 1'b0;
  logic prev_we_b = 1'b0;

  logic [31:0] wa_addr[$], wa_data[$], wb_addr[$], wb_data[$];

  always #5 clk = ~clk;

  loop_recorder_if #(.ADDR_W(16), .DATA_W(4)) bus_a ();
  loop_recorder_if #(.ADDR_W(3),  .DATA_W(4)) bus_b ();

  assign bus_a.sample_stb = stb;
  assign bus_a.sample_in  = smp;
  assign bus_a.rec_req    = rec;
  assign bus_a.play_req   = play;
  assign bus_b.sample_stb = stb;
  assign bus_b.sample_in  = smp;
  assign bus_b.rec_req    = rec;
  assign bus_b.play_req   = play;

  loop_recorder_ctrl #(.ADDR_W(16), .DATA_W(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  loop_recorder_ctrl #(.ADDR_W(3),  .DATA_W(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  logic [3:0] mem_a [65536];
  logic [3:0] mem_b [8];

  always @(posedge clk) begin
    if (bus_a.buf_we) mem_a[bus_a.buf_waddr] <= bus_a.buf_wdata;
    bus_a.buf_rdata <= mem_a[bus_a.buf_raddr];
    if (bus_b.buf_we) mem_b[bus_b.buf_waddr] <= bus_b.buf_wdata;
    bus_b.buf_rdata <= mem_b[bus_b.buf_raddr];
  end

  // Log writes; flag any strobe outside RECORD or lasting more than one cycle.
  always @(negedge clk) begin
    if (bus_a.buf_we) begin
      wa_addr.push_back(32'(bus_a.buf_waddr));
      wa_data.push_back(32'(bus_a.buf_wdata));
      if (bus_a.state != 2'b01 || prev_we_a) bad_we++;
    end
    if (bus_b.buf_we) begin
      wb_addr.push_back(32'(bus_b.buf_waddr));
      wb_data.push_back(32'(bus_b.buf_wdata));
      if (bus_b.state != 2'b01 || prev_we_b) bad_we++;
    end
    prev_we_a = bus_a.buf_we;
    prev_we_b = bus_b.buf_we;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] v);
    smp = v;
    stb = 1'b1;
    tick();
    stb = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    // Reset with rec_req held high: must not trigger on release.
    rec = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check_eq("rst_state", 32'(bus_a.state), 0);
    check_eq("rst_rec_len", 32'(bus_a.rec_len), 0);
    check_eq("rst_full", 32'(bus_a.full), 0);
    check_eq("rst_audio", 32'(bus_a.audio_out), 0);
    check_eq("rst_waddr", 32'(bus_a.buf_waddr), 0);
    check_eq("rst_raddr", 32'(bus_a.buf_raddr), 0);
    check_eq("rst_we_cnt", 32'(wa_addr.size()), 0);
    rec = 1'b0;
    tick();

    // Record five samples 1..5 with cycle-exact write checks.
    rec = 1'b1;
    tick();
    check_eq("rec_state", 32'(bus_a.state), 1);
    for (int i = 0; i < 5; i++) begin
      smp = 4'(i + 1);
      stb = 1'b1;
      tick();
      stb = 1'b0;
      check_eq("rec_we", 32'(bus_a.buf_we), 1);
      check_eq("rec_waddr", 32'(bus_a.buf_waddr), 32'(i));
      check_eq("rec_wdata", 32'(bus_a.buf_wdata), 32'(i + 1));
      tick();
      check_eq("rec_we_low", 32'(bus_a.buf_we), 0);
      tick();
    end
    check_eq("rec_monitor", 32'(bus_a.audio_out), 5);
    rec = 1'b0;
    tick();
    check_eq("rec_done_state", 32'(bus_a.state), 0);
    check_eq("rec_len_a", 32'(bus_a.rec_len), 5);
    check_eq("rec_len_b", 32'(bus_b.rec_len), 5);
    check_eq("rec_full", 32'(bus_a.full), 0);
    check_eq("rec_nwrites", 32'(wa_addr.size()), 5);
    for (int i = 0; i < wa_addr.size(); i++) begin
      check_eq("rec_log_addr", wa_addr[i], 32'(i));
      check_eq("rec_log_data", wa_data[i], 32'(i + 1));
    end

    // Loop playback of twelve strobes.
    play = 1'b1;
    tick();
    check_eq("play_state", 32'(bus_a.state), 2);
    tick();
    for (int i = 0; i < 12; i++) begin
      stb = 1'b1;
      tick();
      stb = 1'b0;
      check_eq("play_audio_a", 32'(bus_a.audio_out), 32'((i % 5) + 1));
      check_eq("play_audio_b", 32'(bus_b.audio_out), 32'((i % 5) + 1));
      tick();
      tick();
    end
    play = 1'b0;
    tick();
    check_eq("play_exit_state", 32'(bus_a.state), 0);
    check_eq("play_hold_audio", 32'(bus_a.audio_out), 2);
    check_eq("play_rec_len_kept", 32'(bus_a.rec_len), 5);

    // Both requests rise together: RECORD wins; then empty recording blocks PLAY.
    rec = 1'b1;
    play = 1'b1;
    tick();
    check_eq("both_rise_state", 32'(bus_a.state), 1);
    rec = 1'b0;
    tick();
    check_eq("empty_rec_state", 32'(bus_a.state), 0);
    check_eq("empty_rec_len", 32'(bus_a.rec_len), 0);
    play = 1'b0;
    tick();
    play = 1'b1;
    tick();
    tick();
    check_eq("play_len0_state", 32'(bus_a.state), 0);
    play = 1'b0;
    tick();

    // Overfill: tiny buffer stops at 8 writes and flags full.
    wa_addr.delete();
    wa_data.delete();
    wb_addr.delete();
    wb_data.delete();
    rec = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) pulse(4'(i + 1));
    check_eq("full_b_state", 32'(bus_b.state), 0);
    check_eq("full_b_flag", 32'(bus_b.full), 1);
    check_eq("full_b_len", 32'(bus_b.rec_len), 8);
    check_eq("full_b_nwrites", 32'(wb_addr.size()), 8);
    for (int i = 0; i < wb_addr.size(); i++) begin
      check_eq("full_b_addr", wb_addr[i], 32'(i));
      check_eq("full_b_data", wb_data[i], 32'(i + 1));
    end
    check_eq("full_b_monitor", 32'(bus_b.audio_out), 10);
    check_eq("full_a_state", 32'(bus_a.state), 1);
    rec = 1'b0;
    tick();
    check_eq("full_a_len", 32'(bus_a.rec_len), 10);
    check_eq("full_a_flag", 32'(bus_a.full), 0);
    check_eq("full_a_nwrites", 32'(wa_addr.size()), 10);

    // Reset in the middle of playback.
    play = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      stb = 1'b1;
      tick();
      stb = 1'b0;
      check_eq("mid_play_audio", 32'(bus_a.audio_out), 32'(i + 1));
      tick();
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("mid_rst_state", 32'(bus_a.state), 0);
    check_eq("mid_rst_len", 32'(bus_a.rec_len), 0);
    check_eq("mid_rst_audio", 32'(bus_a.audio_out), 0);
    check_eq("mid_rst_raddr", 32'(bus_a.buf_raddr), 0);
    play = 1'b0;
    tick();
    play = 1'b1;
    tick();
    tick();
    check_eq("post_rst_play_ignored", 32'(bus_a.state), 0);
    play = 1'b0;
    tick();

    check_eq("we_discipline", 32'(bad_we), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/loop_recorder_ctrl.md
# loop_recorder_ctrl

Sequencer for the audio sample buffer: records microphone samples into the buffer on request, then plays them back as a seamless loop. Sits between the microphone decimator (sample source) and the buffer RAM, and drives the audio DAC nibble. Replaces free-running up/down address counting with explicit record length, full detection and loop wrap.

## Interface
- ADDR_W, 16, buffer address width; capacity 2^ADDR_W samples
- DATA_W, 4, sample width
- clk  in  1  system clock, also clocks the buffer RAM
- rst_n  in  1  synchronous, active-low reset
- sample_stb  in  1  one-cycle pulse per audio sample, synchronous to clk; pulses ≥3 cycles apart
- sample_in  in  DATA_W  microphone sample, valid when sample_stb=1
- rec_req  in  1  record request level, debounced, synchronous
- play_req  in  1  playback request level, debounced, synchronous
- buf_we  out  1  buffer write enable
- buf_waddr  out  ADDR_W  buffer write address
- buf_wdata  out  DATA_W  buffer write data
- buf_raddr  out  ADDR_W  buffer read address
- buf_rdata  in  DATA_W  buffer read data; registered RAM, valid 1 cycle after buf_raddr
- audio_out  out  DATA_W  sample to DAC
- rec_len  out  ADDR_W+1  number of samples in last completed recording
- state  out  2  00 IDLE, 01 RECORD, 10 PLAY
- full  out  1  last recording stopped because buffer filled

## Operation
- States: IDLE, RECORD, PLAY. Reset: IDLE; all outputs 0; internal write/read pointers 0; rec_req/play_req history registers reset to 1 (a request held through reset does not trigger).
- Rising edge = req & ~req_q, req_q registered every cycle in all states. Edges seen outside IDLE are discarded; a new edge is needed after returning to IDLE.
- IDLE -> RECORD on rec_req rising: waddr<=0, count<=0, full<=0. Rising on both requests in the same cycle: RECORD wins.
- IDLE -> PLAY on play_req rising only if rec_len≠0; otherwise stays IDLE. Entry: raddr<=0.
- RECORD: on sample_stb, buf_wdata<=sample_in, buf_we<=1 (next cycle). In the cycle buf_we=1: waddr<=waddr+1, count<=count+1, buf_we<=0. buf_waddr = waddr throughout.
- RECORD exit: rec_req low -> IDLE, rec_len<=count including any write committed in that same cycle. Count reaching 2^ADDR_W -> IDLE, full<=1, rec_len<=2^ADDR_W; waddr wraps to 0 but no further write occurs.
- PLAY: buf_raddr = raddr. On sample_stb: audio_out<=buf_rdata, raddr<=(raddr==rec_len-1)?0:raddr+1. play_req low -> IDLE, audio_out holds last value.
- IDLE and RECORD: on sample_stb, audio_out<=sample_in (monitor passthrough).
- rec_len and buffer contents persist across PLAY and IDLE until next RECORD entry; rec_len keeps its old value during RECORD until exit.
- Reset mid-RECORD or mid-PLAY: immediate return to reset values; rec_len lost (0); pending write dropped.

## Timing
- State transition registered: one cycle after the triggering edge/level is sampled.
- Write latency: sample_stb at cycle N -> buf_we=1 at N+1 with buf_wdata=sample, buf_waddr=address; pointer advances at N+2.
- Read: raddr changes at stb edge; rdata valid after 1 cycle; stb spacing ≥3 guarantees rdata stable at next stb. First PLAY stb outputs sample 0.
- buf_we never asserted outside RECORD, never for more than 1 cycle per stb.
- rec_len-1 computed in ADDR_W+1 bits; with rec_len=2^ADDR_W, wrap at raddr=2^ADDR_W-1.

## Test plan
- Reset with rec_req held high, release reset -> stays IDLE, state=00, all outputs 0, no buf_we.
- rec_req rise, 5 stbs with samples 1,2,3,4,5, drop rec_req -> writes addr 0..4 with 1..5, rec_len=5, full=0, state=00.
- After above, play_req rise, 12 stbs -> audio_out 1,2,3,4,5,1,2,3,4,5,1,2; release -> IDLE, audio_out holds 2.
- ADDR_W=3, hold rec_req, 10 stbs -> exactly 8 writes (addr 0..7), auto IDLE, full=1, rec_len=8, further stbs write nothing.
- rec_req and play_req rise same cycle -> RECORD; play_req rise with rec_len=0 -> stays IDLE.
- rst_n low for 1 cycle mid-PLAY -> state=00, rec_len=0, audio_out=0 next cycle; subsequent play_req rise ignored.
